fp_div_seq: RTL and testbench

- Iterative IEEE-754 single-precision divider (fp_Z = fp_X / fp_Y), the inverse companion of the FPU multiplier.
- Uses radix-2 restoring division with a valid/ready handshake on input and output.
- Shares the multiplier's r_mode encoding, flush-to-zero subnormal policy and ovrf/udrf flag semantics. Sits in the FPU datapath beside the multiplier.

---
 rtl/fp_div_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_seq
// Brief    : Iterative IEEE-754 single-precision divider (radix-2 restoring)
//            with valid/ready handshake, flush-to-zero subnormals.
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_seq #(
   parameter int          QBITS     = 26,
   parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp_X,
   input  logic [31:0] fp_Y,
   input  logic [2:0]  r_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fp_Z,
   output logic        ovrf,
   output logic        udrf,
   output logic        dz
);

   localparam int              c_CW       = $clog2(QBITS + 1);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(QBITS - 1);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_SPEC = 3'd1;
   localparam logic [2:0] c_DIV  = 3'd2;
   localparam logic [2:0] c_RND  = 3'd3;
   localparam logic [2:0] c_DONE = 3'd4;

   localparam logic [2:0] c_RNE = 3'd0;
   localparam logic [2:0] c_RTZ = 3'd1;
   localparam logic [2:0] c_RDN = 3'd2;
   localparam logic [2:0] c_RUP = 3'd3;
   localparam logic [2:0] c_RMM = 3'd4;

   logic [2:0]       r_state, w_next;
   logic [c_CW-1:0]  r_cnt;
   logic [2:0]       r_rnd_mode;
   logic             r_sign;
   logic [9:0]       r_exp;
   logic [25:0]      r_rem;
   logic [23:0]      r_div;
   logic [QBITS-1:0] r_q;
   logic [31:0]      r_spec_z;
   logic             r_spec_dz;
   logic [31:0]      r_z;
   logic             r_ovrf, r_udrf, r_dz;

   // ---------------- operand classification at accept ----------------
   logic [7:0]  w_ex, w_ey;
   logic [22:0] w_fx, w_fy;
   logic        w_x_zero, w_x_inf, w_x_nan, w_y_zero, w_y_inf, w_y_nan;
   logic        w_sign_in, w_accept, w_lt;
   logic        w_is_spec, w_spec_dz;
   logic [31:0] w_spec_z;
   logic [23:0] w_mx, w_my;
   logic [25:0] w_rem0;
   logic [9:0]  w_exp0;

   assign w_ex      = fp_X[30:23];
   assign w_ey      = fp_Y[30:23];
   assign w_fx      = fp_X[22:0];
   assign w_fy      = fp_Y[22:0];
   assign w_x_zero  = (w_ex == 8'h00);
   assign w_y_zero  = (w_ey == 8'h00);
   assign w_x_inf   = (w_ex == 8'hFF) && (w_fx == 23'd0);
   assign w_y_inf   = (w_ey == 8'hFF) && (w_fy == 23'd0);
   assign w_x_nan   = (w_ex == 8'hFF) && (w_fx != 23'd0);
   assign w_y_nan   = (w_ey == 8'hFF) && (w_fy != 23'd0);
   assign w_sign_in = fp_X[31] ^ fp_Y[31];
   assign w_accept  = in_valid && in_ready;

   always_comb begin
      w_is_spec = 1'b1;
      w_spec_z  = NAN_CANON;
      w_spec_dz = 1'b0;
      if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf)) begin
         w_spec_z = NAN_CANON;
      end else if (w_y_zero) begin
         w_spec_z  = {w_sign_in, 8'hFF, 23'd0};
         w_spec_dz = !w_x_inf;
      end else if (w_x_inf) begin
         w_spec_z = {w_sign_in, 8'hFF, 23'd0};
      end else if (w_x_zero || w_y_inf) begin
         w_spec_z = {w_sign_in, 31'd0};
      end else begin
         w_is_spec = 1'b0;
      end
   end

   // Pre-normalise so the quotient lands in [1,2) and its first bit is 1.
   assign w_mx   = {1'b1, w_fx};
   assign w_my   = {1'b1, w_fy};
   assign w_lt   = (w_mx < w_my);
   assign w_rem0 = w_lt ? {1'b0, w_mx, 1'b0} : {2'b00, w_mx};
   assign w_exp0 = {2'b00, w_ex} - {2'b00, w_ey} + 10'd127 - {9'd0, w_lt};

   // ---------------- restoring iteration ----------------
   logic [25:0] w_diff, w_rem_nxt;
   logic        w_ge;

   assign w_ge      = (r_rem >= {2'b00, r_div});
   assign w_diff    = r_rem - {2'b00, r_div};
   assign w_rem_nxt = w_ge ? {w_diff[24:0], 1'b0} : {r_rem[24:0], 1'b0};

   // ---------------- rounding ----------------
   logic [23:0] w_sig;
   logic        w_g, w_r, w_s, w_inexact, w_inc;
   logic [24:0] w_sum;
   logic [9:0]  w_exp_r;
   logic [22:0] w_frac;
   logic        w_ovf, w_udf;
   logic [31:0] w_rnd_z, w_ovf_z;

   assign w_sig     = r_q[QBITS-1 -: 24];
   assign w_g       = r_q[1];
   assign w_r       = r_q[0];
   assign w_s       = (r_rem != 26'd0);
   assign w_inexact = w_g | w_r | w_s;

   always_comb begin
      w_inc = 1'b0;
      case (r_rnd_mode)
         c_RTZ:   w_inc = 1'b0;
         c_RDN:   w_inc = r_sign & w_inexact;
         c_RUP:   w_inc = !r_sign & w_inexact;
         c_RMM:   w_inc = w_g;
         default: w_inc = w_g & (w_r | w_s | w_sig[0]);
      endcase
   end

   assign w_sum   = {1'b0, w_sig} + {24'd0, w_inc};
   assign w_exp_r = r_exp + {9'd0, w_sum[24]};
   assign w_frac  = w_sum[24] ? 23'd0 : w_sum[22:0];
   assign w_ovf   = !w_exp_r[9] && (w_exp_r[8:0] >= 9'd255);
   assign w_udf   = w_exp_r[9] || (w_exp_r == 10'd0);

   always_comb begin
      w_ovf_z = {r_sign, 8'hFF, 23'd0};
      case (r_rnd_mode)
         c_RTZ:   w_ovf_z = {r_sign, 31'h7F7FFFFF};
         c_RDN:   w_ovf_z = r_sign ? 32'hFF800000 : 32'h7F7FFFFF;
         c_RUP:   w_ovf_z = r_sign ? 32'hFF7FFFFF : 32'h7F800000;
         default: w_ovf_z = {r_sign, 8'hFF, 23'd0};
      endcase
   end

   always_comb begin
      w_rnd_z = {r_sign, w_exp_r[7:0], w_frac};
      if (w_ovf)
         w_rnd_z = w_ovf_z;
      else if (w_udf)
         w_rnd_z = {r_sign, 31'd0};
   end

   logic w_unused;
   assign w_unused = &{1'b0, w_sum[23], w_diff[25]};

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= c_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_next = w_is_spec ? c_SPEC : c_DIV;
         c_SPEC:  w_next = c_DONE;
         c_DIV:   if (r_cnt == c_CNT_LAST) w_next = c_RND;
         c_RND:   w_next = c_DONE;
         c_DONE:  if (out_ready) w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == c_IDLE);
      out_valid = (r_state == c_DONE);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_rnd_mode <= 3'd0;
         r_sign     <= 1'b0;
         r_exp      <= 10'd0;
         r_rem      <= 26'd0;
         r_div      <= 24'd0;
         r_q        <= '0;
         r_spec_z   <= 32'd0;
         r_spec_dz  <= 1'b0;
         r_z        <= 32'd0;
         r_ovrf     <= 1'b0;
         r_udrf     <= 1'b0;
         r_dz       <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: if (w_accept) begin
               r_rnd_mode <= (r_mode > c_RMM) ? c_RNE : r_mode;
               r_sign     <= w_sign_in;
               r_exp      <= w_exp0;
               r_rem      <= w_rem0;
               r_div      <= w_my;
               r_q        <= '0;
               r_cnt      <= '0;
               r_spec_z   <= w_spec_z;
               r_spec_dz  <= w_spec_dz;
               r_ovrf     <= 1'b0;
               r_udrf     <= 1'b0;
               r_dz       <= 1'b0;
            end
            c_SPEC: begin
               r_z  <= r_spec_z;
               r_dz <= r_spec_dz;
            end
            c_DIV: begin
               r_q   <= {r_q[QBITS-2:0], w_ge};
               r_rem <= w_rem_nxt;
               r_cnt <= r_cnt + c_CNT_ONE;
            end
            c_RND: begin
               r_z    <= w_rnd_z;
               r_ovrf <= w_ovf;
               r_udrf <= w_udf && !w_ovf;
            end
            default: ;
         endcase
      end
   end

   assign fp_Z = r_z;
   assign ovrf = r_ovrf;
   assign udrf = r_udrf;
   assign dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_seq
// Brief    : Directed vector bench for fp_div_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_seq;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [31:0] fp_X, fp_Y;
   logic [2:0]  r_mode;
   logic        out_valid, out_ready;
   logic [31:0] fp_Z;
   logic        ovrf, udrf, dz;

   int checks = 0;
   int errors = 0;

   fp_div_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fp_X      (fp_X),
      .fp_Y      (fp_Y),
      .r_mode    (r_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp_Z      (fp_Z),
      .ovrf      (ovrf),
      .udrf      (udrf),
      .dz        (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  m;
      logic [31:0] z;
      logic [2:0]  flg;   // {ovrf, udrf, dz}
      int          lat;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Presents operands and returns just after the accepting edge.
   task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      fp_X = x; fp_Y = y; r_mode = m; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      fp_X = 32'hDEADBEEF; fp_Y = 32'h12345678; r_mode = 3'd3;
   endtask

   // Counts edges from the accepting edge until out_valid is seen.
   task automatic wait_done(output int lat, output bit busy_bad);
      lat = 1;
      busy_bad = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) chk("done_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int          lat;
      bit          busy_bad;
      logic [31:0] held;

      vecs[0]  = '{32'h40C00000, 32'h40400000, 3'd0, 32'h40000000, 3'b000, 28};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b000, 28};
      vecs[2]  = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b000, 28};
      vecs[3]  = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 3'b000, 28};
      vecs[4]  = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 3'b000, 28};
      vecs[5]  = '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 3'b000, 28};
      vecs[6]  = '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 3'b000, 28};
      vecs[7]  = '{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 3'b000, 28};
      vecs[8]  = '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 3'b001, 2};
      vecs[9]  = '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 3'b000, 2};
      vecs[10] = '{32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, 3'b000, 2};
      vecs[11] = '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 3'b000, 2};
      vecs[12] = '{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 3'b000, 2};
      vecs[13] = '{32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 3'b000, 2};
      vecs[14] = '{32'h7F7FFFFF, 32'h3E800000, 3'd0, 32'h7F800000, 3'b100, 28};
      vecs[15] = '{32'h7F7FFFFF, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 3'b100, 28};
      vecs[16] = '{32'h7F7FFFFF, 32'h3E800000, 3'd2, 32'h7F7FFFFF, 3'b100, 28};
      vecs[17] = '{32'hFF7FFFFF, 32'h3E800000, 3'd3, 32'hFF7FFFFF, 3'b100, 28};
      vecs[18] = '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 3'b010, 28};
      vecs[19] = '{32'hFF7FFFFF, 32'h3E800000, 3'd0, 32'hFF800000, 3'b100, 28};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      fp_X = 32'd0; fp_Y = 32'd0; r_mode = 3'd0;
      #12;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_fp_Z", fp_Z, 32'd0);
      chk("reset_flags", 32'({ovrf, udrf, dz}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) begin
         start_op(vecs[i].x, vecs[i].y, vecs[i].m);
         wait_done(lat, busy_bad);
         chk($sformatf("v%0d_fp_Z", i), fp_Z, vecs[i].z);
         chk($sformatf("v%0d_flags", i), 32'({ovrf, udrf, dz}), 32'(vecs[i].flg));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_busy_ready", i), 32'(busy_bad), 32'd0);
         release_result();
         chk($sformatf("v%0d_release", i), 32'({in_ready, out_valid}), 32'b10);
      end

      // Backpressure: result held, new operands ignored while DONE.
      start_op(32'h40C00000, 32'h40400000, 3'd0);
      wait_done(lat, busy_bad);
      held = fp_Z;
      chk("bp_result", held, 32'h40000000);
      fp_X = 32'h3F800000; fp_Y = 32'h00000000; r_mode = 3'd0;
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d", c),
             {fp_Z[31:3], 3'(out_valid), 1'b0, 1'b0} ,
             {held[31:3], 3'd1, 1'b0, 1'b0});
         chk($sformatf("bp_ready%0d", c), 32'({in_ready, ovrf, udrf, dz}), 32'd0);
      end
      in_valid = 1'b0;
      release_result();
      chk("bp_release", 32'({in_ready, out_valid}), 32'b10);
      chk("bp_no_accept_z", fp_Z, 32'h40000000);

      // Asynchronous reset mid-division, then a clean division.
      start_op(32'h3F800000, 32'h40400000, 3'd0);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_ready_valid", 32'({in_ready, out_valid}), 32'b10);
      chk("midrst_fp_Z", fp_Z, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      start_op(32'h40C00000, 32'h40400000, 3'd0);
      wait_done(lat, busy_bad);
      chk("postrst_fp_Z", fp_Z, 32'h40000000);
      chk("postrst_flags", 32'({ovrf, udrf, dz}), 32'd0);
      chk("postrst_latency", 32'(lat), 32'd28);
      release_result();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
